// File: rtl/fibonacci_seq_gen_if.sv
// Handshake bundle for fibonacci_seq_gen: request side (start/term/seeds/abort),
// stream side (out_* with valid/ready) and status (busy/done/overflow).
interface fibonacci_seq_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TERM_WIDTH = 5
);
    logic                  start;
    logic [TERM_WIDTH-1:0] term;
    logic [DATA_WIDTH-1:0] seed0;
    logic [DATA_WIDTH-1:0] seed1;
    logic                  abort;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [TERM_WIDTH-1:0] out_index;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output start, term, seed0, seed1, abort, out_ready,
        input  out_valid, out_data, out_index, out_last,
        input  busy, done, overflow
    );

    modport slave (
        input  start, term, seed0, seed1, abort, out_ready,
        output out_valid, out_data, out_index, out_last,
        output busy, done, overflow
    );
endinterface

// File: rtl/fibonacci_seq_gen.sv
// Streams N Fibonacci terms F(0..N-1) from two seeds over a valid/ready port.
// Ports: clk, rst (async, active-high), bus (slave side of fibonacci_seq_gen_if).
module fibonacci_seq_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int TERM_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    fibonacci_seq_gen_if.slave    bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [TERM_WIDTH-1:0] ONE = TERM_WIDTH'(1);

    state_t                state_q, state_d;
    logic [TERM_WIDTH-1:0] n_q, n_d;
    logic [TERM_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] nxt_q, nxt_d;
    logic                  nxt_cy_q, nxt_cy_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH:0]   sum;
    logic [TERM_WIDTH-1:0] idx_inc;
    logic [TERM_WIDTH-1:0] n_dec;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        nxt_cy_d = nxt_cy_q;
        last_d   = last_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        sum      = {1'b0, cur_q} + {1'b0, nxt_q};
        idx_inc  = idx_q + ONE;
        n_dec    = n_q - ONE;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ovf_d = 1'b0;
                    if (bus.term == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        n_d      = bus.term;
                        idx_d    = '0;
                        cur_d    = bus.seed0;
                        nxt_d    = bus.seed1;
                        nxt_cy_d = 1'b0;
                        last_d   = (bus.term == ONE);
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // nxt_q becomes the presented term; its carry
                        // was captured when it was summed.
                        idx_d              = idx_inc;
                        cur_d              = nxt_q;
                        {nxt_cy_d, nxt_d}  = sum;
                        ovf_d              = ovf_q | nxt_cy_q;
                        last_d             = (idx_inc == n_dec);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            nxt_cy_q <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            nxt_cy_q <= nxt_cy_d;
            last_q   <= last_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out_valid = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_data  = cur_q;
    assign bus.out_index = idx_q;
    assign bus.out_last  = last_q & (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fibonacci_seq_gen.sv
// Randomized self-checking bench for fibonacci_seq_gen against a plain
// arithmetic Fibonacci model.
module tb_fibonacci_seq_gen;
    localparam int DW = 8;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int   exp_d[$];
    bit   exp_o[$];

    fibonacci_seq_gen_if #(.DATA_WIDTH(DW), .TERM_WIDTH(TW)) bus ();

    fibonacci_seq_gen #(.DATA_WIDTH(DW), .TERM_WIDTH(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void build(input int n, input int s0, input int s1);
        int a, b, s;
        bit o;
        exp_d.delete();
        exp_o.delete();
        a = s0;
        b = s1;
        o = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == 0) exp_d.push_back(a);
            else if (k == 1) exp_d.push_back(b);
            else begin
                s = a + b;
                if (s > (1 << DW) - 1) o = 1'b1;
                s = s % (1 << DW);
                a = b;
                b = s;
                exp_d.push_back(s);
            end
            exp_o.push_back(o);
        end
    endfunction

    task automatic drive_start(input int n, input int s0, input int s1);
        bus.term  = TW'(n);
        bus.seed0 = DW'(s0);
        bus.seed1 = DW'(s1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready
    task automatic test_stream(input string name, input int n,
                               input int s0, input int s1, input int mode);
        int k, cyc;
        bit rdy;
        build(n, s0, s1);
        drive_start(n, s0, s1);
        k = 0;
        cyc = 0;
        while (k < n && cyc < 400) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(exp_d[k]) ||
                bus.out_index !== TW'(k) || bus.out_last !== (k == n - 1) ||
                bus.overflow !== exp_o[k] || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s term%0d: got v=%b d=%0d i=%0d l=%b o=%b, want v=1 d=%0d i=%0d l=%b o=%b",
                         name, k, bus.out_valid, bus.out_data, bus.out_index,
                         bus.out_last, bus.overflow, exp_d[k], k, (k == n - 1), exp_o[k]);
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 3 == 0);
            else rdy = 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            @(posedge clk); #1;
            if (rdy) k++;
            cyc++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (cyc >= 400) begin
            errors++;
            $display("FAIL %s timeout: got %0d terms, want %0d", name, k, n);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end: got v=%b done=%b busy=%b, want 0 1 0",
                     name, bus.out_valid, bus.done, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b v=%b, want 0 0",
                     name, bus.done, bus.out_valid);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last,
             bus.busy, bus.done, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%0d i=%0d l=%b b=%b dn=%b o=%b, want all 0",
                     bus.out_valid, bus.out_data, bus.out_index, bus.out_last,
                     bus.busy, bus.done, bus.overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_overflow;
        test_stream("ovf14", 14, 1, 1, 0);
        checks++;
        if (bus.overflow !== 1'b1 || exp_d[13] != 121) begin
            errors++;
            $display("FAIL ovf_sticky: got o=%b, want 1 (model F13=%0d want 121)",
                     bus.overflow, exp_d[13]);
        end
        test_stream("ovf_clear", 3, 5, 6, 0);
    endtask

    task automatic test_zero;
        drive_start(0, 9, 9);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_term: got v=%b done=%b busy=%b, want 0 1 0",
                     bus.out_valid, bus.done, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got v=%b done=%b, want 0 0",
                     bus.out_valid, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        drive_start(1, 7, 9);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd7 ||
            bus.out_index !== 5'd0 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL n1_term: got v=%b d=%0d i=%0d l=%b, want 1 7 0 1",
                     bus.out_valid, bus.out_data, bus.out_index, bus.out_last);
        end
        // start held through RUN must be ignored, then taken in the done cycle
        bus.term = 5'd2;
        bus.seed0 = 8'd4;
        bus.seed1 = 8'd5;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got v=%b done=%b, want 0 1",
                     bus.out_valid, bus.done);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd4 ||
            bus.out_index !== 5'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got v=%b d=%0d i=%0d done=%b, want 1 4 0 0",
                     bus.out_valid, bus.out_data, bus.out_index, bus.done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_data !== 8'd5 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got d=%0d l=%b, want 5 1",
                     bus.out_data, bus.out_last);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got done=%b v=%b, want 1 0",
                     bus.done, bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        build(10, 1, 1);
        drive_start(10, 1, 1);
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.out_index !== 5'd3 || bus.out_data !== DW'(exp_d[3])) begin
            errors++;
            $display("FAIL abort_pre: got i=%0d d=%0d, want 3 %0d",
                     bus.out_index, bus.out_data, exp_d[3]);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: got v=%b done=%b busy=%b, want 0 0 0",
                     bus.out_valid, bus.done, bus.busy);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got v=%b done=%b busy=%b, want 0 0 0",
                     bus.out_valid, bus.done, bus.busy);
        end
        test_stream("abort_restart", 6, 2, 3, 0);
    endtask

    task automatic test_mid_reset;
        build(10, 1, 1);
        drive_start(10, 1, 1);
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.out_index !== 5'd5 || bus.out_data !== 8'd8) begin
            errors++;
            $display("FAIL rst_pre: got i=%0d d=%0d, want 5 8",
                     bus.out_index, bus.out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last,
             bus.busy, bus.done, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL rst_async: got v=%b d=%0d i=%0d l=%b b=%b dn=%b o=%b, want all 0",
                     bus.out_valid, bus.out_data, bus.out_index, bus.out_last,
                     bus.busy, bus.done, bus.overflow);
        end
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        test_stream("rst_restart", 4, 1, 1, 0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            test_stream("random", int'($urandom_range(1, 20)),
                        int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), 2);
        end
        test_stream("max_n", 31, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.term = '0;
        bus.seed0 = '0;
        bus.seed1 = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_stream("basic", 8, 1, 1, 0);
        test_stream("stall", 8, 1, 1, 1);
        test_overflow();
        test_zero();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
